// File: rtl/isa_pkg.sv
// ISA constants, instruction field positions and fetch FSM states shared by the fetch unit.
package isa_pkg;

    localparam logic [4:0] OPC_NOP = 5'h00;
    localparam logic [4:0] OPC_J   = 5'h16;
    localparam logic [4:0] OPC_BEQ = 5'h17;
    localparam logic [4:0] OPC_HLT = 5'h18;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 27;
    localparam int unsigned DEST_MSB = 26;
    localparam int unsigned DEST_LSB = 18;
    localparam int unsigned SRC1_MSB = 17;
    localparam int unsigned SRC1_LSB = 9;
    localparam int unsigned SRC2_MSB = 8;
    localparam int unsigned SRC2_LSB = 0;

    localparam int unsigned FLAG_Z = 2;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection for the retiring instruction (jump, branch-if-zero, halt, sequential).
module instr_fetch_pc_next
    import isa_pkg::*;
#(
    parameter int unsigned OPCODE_SIZE = 5,
    parameter int unsigned PC_WIDTH    = 9
) (
    input  logic [PC_WIDTH-1:0]    pc_i,
    input  logic [OPCODE_SIZE-1:0] opcode_i,
    input  logic [PC_WIDTH-1:0]    target_i,
    input  logic [3:0]             flags_i,
    output logic [PC_WIDTH-1:0]    pc_next_o
);

    logic [PC_WIDTH-1:0] pc_inc;
    logic                unused_flags;

    // Sequential successor wraps naturally at the PC width.
    assign pc_inc       = pc_i + PC_WIDTH'(1);
    assign unused_flags = ^(flags_i & ~(4'b0001 << FLAG_Z));

    always_comb begin
        pc_next_o = pc_inc;
        if (opcode_i == OPCODE_SIZE'(OPC_J)) begin
            pc_next_o = target_i;
        end else if (opcode_i == OPCODE_SIZE'(OPC_BEQ)) begin
            pc_next_o = flags_i[FLAG_Z] ? target_i : pc_inc;
        end else if (opcode_i == OPCODE_SIZE'(OPC_HLT)) begin
            pc_next_o = pc_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: request, hold for decoder handshake, redirect or halt.
// Optional retired-instruction counter enabled by macro IFETCH_RETIRE_CNT_EN.
module instr_fetch
    import isa_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned OPCODE_SIZE = 5,
    parameter int unsigned PC_WIDTH    = 9,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic [3:0]           flags,
    output logic                 halted
`ifdef IFETCH_RETIRE_CNT_EN
    ,
    output logic [31:0]          retire_cnt
`endif
);

    fetch_state_e         state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]  pc_next;
    logic                 handshake;
    logic [OPCODE_SIZE-1:0] opcode;
    logic [PC_WIDTH-1:0]  target;

    assign opcode    = instr_q[OPC_MSB -: OPCODE_SIZE];
    assign target    = PC_WIDTH'(instr_q[DEST_MSB:DEST_LSB]);
    assign handshake = (state_q == ST_ISSUE) && instr_ready;
    assign imem_addr = pc_q;
    assign instr     = instr_q;

    instr_fetch_pc_next #(
        .OPCODE_SIZE (OPCODE_SIZE),
        .PC_WIDTH    (PC_WIDTH)
    ) u_pc_next (
        .pc_i      (pc_q),
        .opcode_i  (opcode),
        .target_i  (target),
        .flags_i   (flags),
        .pc_next_o (pc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= PC_WIDTH'(RESET_PC);
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next state and state-decoded handshake outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (handshake) begin
                    pc_d    = pc_next;
                    state_d = (opcode == OPCODE_SIZE'(OPC_HLT)) ? ST_HALTED : ST_REQ;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

`ifdef IFETCH_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (handshake) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter WORD_SIZE, default 32, SHALL set the instruction width.
REQ-002 Parameter OPCODE_SIZE, default 5, SHALL set the opcode field width at instr[31:27].
REQ-003 Parameter PC_WIDTH, default 9, SHALL set the program-counter and jump-target width.
REQ-004 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-005 Port clk, input, 1, SHALL be the clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, SHALL be the reset; asynchronous, active-high.
REQ-007 Port imem_req, output, 1, SHALL request a program-memory read.
REQ-008 Port imem_addr, output, PC_WIDTH, SHALL carry the read address, equal to the current PC.
REQ-009 Port imem_ack, input, 1, SHALL mark imem_rdata valid for the outstanding request.
REQ-010 Port imem_rdata, input, WORD_SIZE, SHALL carry the fetched instruction word.
REQ-011 Port instr, output, WORD_SIZE, SHALL carry the held instruction to the decoder.
REQ-012 Port instr_valid, output, 1, SHALL mark instr as valid.
REQ-013 Port instr_ready, input, 1, SHALL be asserted by the decoder to accept instr.
REQ-014 Port flags, input, 4, SHALL carry ALU flags {N,Z,C,V}, with Z at flags[2].
REQ-015 Port halted, output, 1, SHALL indicate that HLT has retired.

Function
REQ-016 The FSM SHALL have states REQ, ISSUE and HALTED.
REQ-017 In REQ, imem_req SHALL be 1 and decoded from state; the FSM SHALL stay in REQ until imem_ack=1.
REQ-018 On imem_ack in REQ, imem_rdata SHALL be registered into instr and the FSM SHALL go to ISSUE on the next edge.
REQ-019 In ISSUE, instr_valid SHALL be 1 and instr SHALL stay stable until instr_valid & instr_ready (the handshake).
REQ-020 At the handshake, opcode J (5'h16) SHALL load PC with instr[26:18] truncated to PC_WIDTH, then go to REQ.
REQ-021 At the handshake, opcode BEQ (5'h17) SHALL load PC with instr[26:18] if flags[2]=1 (sampled that cycle), else PC+1, then go to REQ.
REQ-022 At the handshake, opcode HLT (5'h18) SHALL leave PC unchanged and go to HALTED.
REQ-023 At the handshake, any other opcode, including 0, SHALL set PC to PC+1 and go to REQ.
REQ-024 PC+1 SHALL wrap modulo 2^PC_WIDTH, so all-ones goes to 0.
REQ-025 In HALTED: halted=1, imem_req=0, instr_valid=0; exit only by rst.
REQ-026 imem_ack outside REQ SHALL be ignored.
REQ-027 Fetch-to-issue latency SHALL be 1 cycle after imem_ack; issue-to-next-request latency SHALL be 1 cycle after the handshake.
REQ-028 Only one memory request SHALL be outstanding at a time; no prefetch.

Reset
REQ-029 rst SHALL immediately force: state=REQ, PC=RESET_PC, instr=0, instr_valid=0, halted=0.
REQ-030 After rst deasserts, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-031 rst mid-request or mid-issue SHALL abandon the in-flight instruction with no PC update.

Configuration
REQ-032 With macro IFETCH_RETIRE_CNT_EN defined, an output retire_cnt[31:0] SHALL exist, reset to 0, incrementing by 1 per handshake (HLT included) and wrapping at 2^32.
REQ-033 Without IFETCH_RETIRE_CNT_EN, the retire_cnt port and its counter SHALL be absent.

Structure
REQ-034 Package isa_pkg SHALL hold the opcode constants (NOP, J=5'h16, BEQ=5'h17, HLT=5'h18), the field bit positions (opcode 31:27, dest 26:18, src1 17:9, src2 8:0), FLAG_Z=2 and the FSM state enum.
REQ-035 The sub-module instr_fetch_pc_next SHALL compute the next PC from PC, opcode, target and flags, purely combinationally.

Verification
REQ-036 Release rst, ack with rdata=32'h30000000 -> imem_addr=0; instr_valid=1 with instr=32'h30000000 the next cycle; after ready, imem_addr=1.
REQ-037 Fetch 32'hB1540000 (J, target 9'h055), ready=1 -> next imem_addr=9'h055.
REQ-038 Fetch 32'hB8400000 (BEQ, target 9'h010), flags=4'b0100 -> imem_addr=9'h010; repeat with flags=4'b0000 -> imem_addr=PC+1.
REQ-039 Fetch 32'hC0000000 (HLT) -> halted=1; imem_req=0 for 10 cycles despite spurious imem_ack pulses; rst clears halted.
REQ-040 Hold instr_ready=0 for 5 cycles in ISSUE -> instr unchanged and no imem_req; with PC=9'h1FF and a non-branch instruction -> next imem_addr=9'h000.
REQ-041 Assert rst while waiting for ack at PC=9'h023 -> instr_valid=0 immediately; after release, imem_addr=RESET_PC; with IFETCH_RETIRE_CNT_EN, retire_cnt=0.
